slice_add_seq: RTL and testbench
================================

// Module: slice_add_seq
// PURPOSE
//   Multi-cycle wide adder. Adds two W-bit operands (W = N*K) one N-bit slice per
//   clock, LSB slice first, holding the inter-slice carry in a register.
//   Used upstream of result consumers when a full-width single-cycle ripple add
//   does not meet timing. Valid/ready handshake on both input and output sides.
// PARAMETERS
//   N  4  slice width in bits (width of the per-cycle ripple add)
//   K  4  number of slices, >= 1; operand width W = N*K (localparam)
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands a, b, cin are valid
//   in_ready   out  1  block can accept operands (high only in IDLE)
//   a          in   W  operand A
//   b          in   W  operand B
//   cin        in   1  carry into slice 0
//   out_valid  out  1  sum/carry_out hold a completed result
//   out_ready  in   1  consumer accepts result
//   sum        out  W  result, a + b + cin, mod 2^W
//   carry_out  out  1  carry out of the top slice
//   busy       out  1  state != IDLE
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, slice index=0, carry reg=0, sum=0,
//     carry_out=0, out_valid=0; in_ready=1 and busy=0 once in IDLE.
//     Reset mid-RUN or mid-DONE discards the in-flight operation; no result emitted.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch a, b; carry reg<=cin;
//     idx<=0; state<=RUN. in_valid low: stay IDLE, no register change.
//   RUN: each edge computes {c,s} = a[idx*N+:N] + b[idx*N+:N] + carry (N+1 bits);
//     sum[idx*N+:N]<=s; carry<=c; idx<=idx+1. On the edge processing idx==K-1:
//     carry_out<=c, out_valid<=1, state<=DONE. in_ready=0; input ignored.
//   Latency: out_valid rises exactly K edges after the accepting edge (K=1 -> 1).
//   DONE: out_valid=1; sum/carry_out stable. On out_valid&&out_ready: out_valid<=0,
//     state<=IDLE. out_ready low holds DONE indefinitely. in_ready=0 in DONE, so
//     back-to-back throughput is one operation per K+2 cycles minimum.
//   sum/carry_out retain the last result after handoff; meaningful only with out_valid.
//   Unused upper slices of sum are not cleared at accept; all K slices are
//     overwritten before out_valid asserts.
//   Arithmetic is unsigned; overflow appears only in carry_out. in_valid while
//     busy is ignored (operands not latched); upstream must hold until in_ready.
//   idx counter width clog2(K) (min 1); never exceeds K-1.
// TESTING  (N=4, K=4 unless noted)
//   1 a=0x0001 b=0x0001 cin=0 -> out_valid 4 edges after accept, sum=0x0002, co=0.
//   2 a=0xFFFF b=0x0001 cin=0 -> sum=0x0000, co=1 (carry crosses all 4 slices).
//   3 a=0x8000 b=0x8000 cin=1 -> sum=0x0001, co=1; a=0x1234 b=0x4321 -> 0x5555, co=0.
//   4 out_ready low 3 cycles in DONE -> out_valid, sum, co held; in_ready=0; a second
//     in_valid pulse meanwhile not accepted; after out_ready -> IDLE, in_ready=1.
//   5 rst_n low during RUN (idx=2) -> out_valid=0, sum=0 immediately; after release
//     in_ready=1; next op 0x00FF+0x0001 -> 0x0100, co=0.
//   6 K=1, N=4: 0x9+0x4 cin=0 -> 0xD co=0 after 1 edge; 0xD+0x5 -> 0x2, co=1.

Source files
------------

// File: rtl/slice_add_seq.sv
// Multi-cycle wide adder: adds two N*K-bit operands one N-bit slice per clock,
// LSB slice first, with the inter-slice carry held in a register.
module slice_add_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   a,
  input  logic [N*K-1:0]   b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          co_q, co_d;
  logic          ov_q, ov_d;

  logic [N-1:0]  a_sl_s;
  logic [N-1:0]  b_sl_s;
  logic [N-1:0]  add_s_s;
  logic          add_c_s;
  int            shamt_s;
  logic [W-1:0]  slice_mask_s;
  logic [W-1:0]  slice_val_s;

  // Select the operand slices addressed by the slice index (AND-OR mux).
  always_comb begin
    a_sl_s = '0;
    b_sl_s = '0;
    for (int k = 0; k < K; k++) begin
      a_sl_s = a_sl_s | (a_q[k*N +: N] & {N{idx_q == IW'(k)}});
      b_sl_s = b_sl_s | (b_q[k*N +: N] & {N{idx_q == IW'(k)}});
    end
  end

  assign {add_c_s, add_s_s} = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{N{1'b0}}, carry_q};

  assign shamt_s      = int'(idx_q) * N;
  assign slice_mask_s = W'({N{1'b1}}) << shamt_s;
  assign slice_val_s  = W'(add_s_s) << shamt_s;

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d   = (sum_q & ~slice_mask_s) | slice_val_s;
        carry_d = add_c_s;
        if (idx_q == IDX_LAST) begin
          co_d    = add_c_s;
          ov_d    = 1'b1;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          ov_d    = 1'b1;
        end
      end
      default: begin
        ov_d    = 1'b0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_slice_add_seq.sv
// Directed self-checking bench for slice_add_seq: a K=4 instance for the main
// scenarios and a K=1 instance for the single-slice corner.
module tb_slice_add_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, cin, out_valid, out_ready, carry_out, busy;
  logic [15:0] a, b, sum;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, carry_out1, busy1;
  logic [3:0]  a1, b1, sum1;

  int checks;
  int errors;

  slice_add_seq #(.N(4), .K(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  slice_add_seq #(.N(4), .K(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry_out(carry_out1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for exactly one edge (stimulus only).
  task automatic accept4(input logic [15:0] av, input logic [15:0] bv, input logic ci);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handoff4();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks += 5;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (sum !== 16'h0000)   begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry_out: got %b expected 0", carry_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    accept4(16'h0001, 16'h0001, 1'b0);
    checks += 2;
    if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready: got %b expected 0", in_ready); end
    for (int e = 1; e < 4; e++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid edge %0d: got %b expected 0", e, out_valid); end
    end
    @(posedge clk); #1;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", out_valid); end
    if (sum !== 16'h0002)   begin errors++; $display("FAIL basic_sum: got %h expected 0002", sum); end
    if (carry_out !== 1'b0) begin errors++; $display("FAIL basic_co: got %b expected 0", carry_out); end
    handoff4();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_handoff_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL basic_handoff_ready: got %b expected 1", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL basic_handoff_busy: got %b expected 0", busy); end
    if (sum !== 16'h0002)   begin errors++; $display("FAIL basic_sum_retained: got %h expected 0002", sum); end
  endtask

  task automatic test_vectors();
    logic [15:0] va [3] = '{16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] vb [3] = '{16'h0001, 16'h8000, 16'h4321};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] es [3] = '{16'h0000, 16'h0001, 16'h5555};
    logic        ec [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      accept4(va[i], vb[i], vc[i]);
      repeat (4) @(posedge clk);
      #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid: got %b expected 1", i, out_valid); end
      if (sum !== es[i])      begin errors++; $display("FAIL vec%0d_sum: got %h expected %h", i, sum, es[i]); end
      if (carry_out !== ec[i]) begin errors++; $display("FAIL vec%0d_co: got %b expected %b", i, carry_out, ec[i]); end
      handoff4();
    end
  endtask

  task automatic test_backpressure();
    accept4(16'h0F0F, 16'h0101, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid: got %b expected 1", c, out_valid); end
      if (sum !== 16'h1010)   begin errors++; $display("FAIL hold%0d_sum: got %h expected 1010", c, sum); end
      if (carry_out !== 1'b0) begin errors++; $display("FAIL hold%0d_co: got %b expected 0", c, carry_out); end
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold%0d_in_ready: got %b expected 0", c, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    handoff4();
    checks += 2;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL hold_release_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks += 2;
    if (busy !== 1'b0)    begin errors++; $display("FAIL hold_no_accept_busy: got %b expected 0", busy); end
    if (sum !== 16'h1010) begin errors++; $display("FAIL hold_no_accept_sum: got %h expected 1010", sum); end
  endtask

  task automatic test_reset_midrun();
    accept4(16'h1111, 16'h2222, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sum[7:0] !== 8'h33) begin errors++; $display("FAIL midrun_partial: got %h expected 33", sum[7:0]); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_rst_valid: got %b expected 0", out_valid); end
    if (sum !== 16'h0000)   begin errors++; $display("FAIL midrun_rst_sum: got %h expected 0000", sum); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrun_rst_ready: got %b expected 1", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL midrun_rst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_ghost edge %0d: got %b expected 0", e, out_valid); end
    end
    accept4(16'h00FF, 16'h0001, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrun_next_valid: got %b expected 1", out_valid); end
    if (sum !== 16'h0100)   begin errors++; $display("FAIL midrun_next_sum: got %h expected 0100", sum); end
    if (carry_out !== 1'b0) begin errors++; $display("FAIL midrun_next_co: got %b expected 0", carry_out); end
    handoff4();
  endtask

  task automatic test_k1();
    logic [3:0] va [2] = '{4'h9, 4'hD};
    logic [3:0] vb [2] = '{4'h4, 4'h5};
    logic [3:0] es [2] = '{4'hD, 4'h2};
    logic       ec [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      a1 = va[i]; b1 = vb[i]; cin1 = 1'b0; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      checks += 2;
      if (out_valid1 !== 1'b0) begin errors++; $display("FAIL k1_%0d_early: got %b expected 0", i, out_valid1); end
      if (busy1 !== 1'b1)      begin errors++; $display("FAIL k1_%0d_busy: got %b expected 1", i, busy1); end
      @(posedge clk); #1;
      checks += 3;
      if (out_valid1 !== 1'b1)  begin errors++; $display("FAIL k1_%0d_valid: got %b expected 1", i, out_valid1); end
      if (sum1 !== es[i])       begin errors++; $display("FAIL k1_%0d_sum: got %h expected %h", i, sum1, es[i]); end
      if (carry_out1 !== ec[i]) begin errors++; $display("FAIL k1_%0d_co: got %b expected %b", i, carry_out1, ec[i]); end
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      checks++;
      if (in_ready1 !== 1'b1) begin errors++; $display("FAIL k1_%0d_ready: got %b expected 1", i, in_ready1); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_valid = 1'b0; out_ready = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_midrun();
    test_k1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
